reg_file_multiport: RTL and testbench

//  Next-generation CPU register file: parametrised width/depth, two write ports, two read ports.

---
 rtl/reg_file_multiport_if.sv | 47 ++++
 rtl/reg_file_multiport.sv | 125 ++++++++++++
 tb/tb_reg_file_multiport.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_multiport_if.sv
// reg_file_multiport_if
//  Bundles the register-file ports shared between decode/writeback and the register file.
//  master: the CPU side, which drives writes, reserves and read selects and receives read data.
//  slave : the register file itself.
//  Signals:
//   WriteEnable0/SelectInput0/In0  write port 0
//   WriteEnable1/SelectInput1/In1  write port 1 (wins over port 0 on the same address)
//   ReserveEnable/ReserveSelect    mark a register busy (pending producer)
//   SelectA/SelectB                read addresses
//   A/B, BusyA/BusyB               read data and busy bits
//  Timing contract: there is no valid/ready pair; every enable is sampled at each rising
//  Clock edge, and read outputs follow the selects combinationally or one edge later.
interface reg_file_multiport_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              WriteEnable0;
    logic [ADDR_W-1:0] SelectInput0;
    logic [DATA_W-1:0] In0;
    logic              WriteEnable1;
    logic [ADDR_W-1:0] SelectInput1;
    logic [DATA_W-1:0] In1;
    logic              ReserveEnable;
    logic [ADDR_W-1:0] ReserveSelect;
    logic [ADDR_W-1:0] SelectA;
    logic [ADDR_W-1:0] SelectB;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              BusyA;
    logic              BusyB;

    modport master (
        output WriteEnable0, SelectInput0, In0,
        output WriteEnable1, SelectInput1, In1,
        output ReserveEnable, ReserveSelect,
        output SelectA, SelectB,
        input  A, B, BusyA, BusyB
    );

    modport slave (
        input  WriteEnable0, SelectInput0, In0,
        input  WriteEnable1, SelectInput1, In1,
        input  ReserveEnable, ReserveSelect,
        input  SelectA, SelectB,
        output A, B, BusyA, BusyB
    );
endinterface

// File: rtl/reg_file_multiport.sv
// reg_file_multiport
//  CPU register file with two write ports, two read ports, optional write-to-read bypass,
//  optional hardwired-zero register 0, optional registered reads and per-register busy bits.
//  Ports:
//   Clock  rising-edge clock
//   Reset  asynchronous, active-low; clears registers, busy bits and read output registers
//   bus    reg_file_multiport_if.slave (write ports, reserve port, read ports A/B)
//  Parameters: DATA_W, ADDR_W (DEPTH = 2**ADDR_W), ZERO_REG, BYPASS, REG_READ.
module reg_file_multiport #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    parameter int REG_READ = 0
) (
    input logic                  Clock,
    input logic                  Reset,
    reg_file_multiport_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] registers [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;

    // Effective enables: with ZERO_REG, any access aimed at register 0 is dropped here so
    // neither the array nor the busy bits ever change for it.
    logic write0Ok;
    logic write1Ok;
    logic reserveOk;

    always_comb begin
        write0Ok  = bus.WriteEnable0;
        write1Ok  = bus.WriteEnable1;
        reserveOk = bus.ReserveEnable;
        if (ZERO_REG != 0) begin
            if (bus.SelectInput0 == '0)  write0Ok  = 1'b0;
            if (bus.SelectInput1 == '0)  write1Ok  = 1'b0;
            if (bus.ReserveSelect == '0) reserveOk = 1'b0;
        end
    end

    // Writes complete a producer and clear busy; a reserve in the same cycle is a newer
    // producer, so it is applied last and leaves the bit set.
    always_comb begin
        busyNext = busy;
        if (write0Ok)  busyNext[bus.SelectInput0]  = 1'b0;
        if (write1Ok)  busyNext[bus.SelectInput1]  = 1'b0;
        if (reserveOk) busyNext[bus.ReserveSelect] = 1'b1;
    end

    // Port 1 is assigned after port 0 so it wins on an address collision.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) registers[i] <= '0;
            busy <= '0;
        end else begin
            if (write0Ok) registers[bus.SelectInput0] <= bus.In0;
            if (write1Ok) registers[bus.SelectInput1] <= bus.In1;
            busy <= busyNext;
        end
    end

    // Read path value for the current cycle (what a combinational read shows).
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;
    logic              busyRdA;
    logic              busyRdB;
    logic              hitA0, hitA1, hitB0, hitB1;

    always_comb begin
        hitA0   = (BYPASS != 0) && write0Ok && (bus.SelectInput0 == bus.SelectA);
        hitA1   = (BYPASS != 0) && write1Ok && (bus.SelectInput1 == bus.SelectA);
        dataA   = registers[bus.SelectA];
        busyRdA = busy[bus.SelectA];
        if (hitA1)      dataA = bus.In1;
        else if (hitA0) dataA = bus.In0;
        // A bypassed read reports busy as it will be after this edge.
        if (hitA0 || hitA1) busyRdA = busyNext[bus.SelectA];
        if ((ZERO_REG != 0) && (bus.SelectA == '0)) begin
            dataA   = '0;
            busyRdA = 1'b0;
        end
    end

    always_comb begin
        hitB0   = (BYPASS != 0) && write0Ok && (bus.SelectInput0 == bus.SelectB);
        hitB1   = (BYPASS != 0) && write1Ok && (bus.SelectInput1 == bus.SelectB);
        dataB   = registers[bus.SelectB];
        busyRdB = busy[bus.SelectB];
        if (hitB1)      dataB = bus.In1;
        else if (hitB0) dataB = bus.In0;
        if (hitB0 || hitB1) busyRdB = busyNext[bus.SelectB];
        if ((ZERO_REG != 0) && (bus.SelectB == '0)) begin
            dataB   = '0;
            busyRdB = 1'b0;
        end
    end

    generate
        if (REG_READ != 0) begin : g_regRead
            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    bus.A     <= '0;
                    bus.B     <= '0;
                    bus.BusyA <= 1'b0;
                    bus.BusyB <= 1'b0;
                end else begin
                    bus.A     <= dataA;
                    bus.B     <= dataB;
                    bus.BusyA <= busyRdA;
                    bus.BusyB <= busyRdB;
                end
            end
        end else begin : g_combRead
            // Gated by Reset so a bypassed write cannot leak out while reset is held.
            always_comb begin
                bus.A     = Reset ? dataA : '0;
                bus.B     = Reset ? dataB : '0;
                bus.BusyA = Reset && busyRdA;
                bus.BusyB = Reset && busyRdB;
            end
        end
    endgenerate
endmodule

// File: tb/tb_reg_file_multiport.sv
module tb_reg_file_multiport;
    logic Clock;
    logic Reset;
    int   checks;
    int   failures;

    // b0: defaults (bypass, combinational); b1: BYPASS=0; b2: ZERO_REG=1; b3: REG_READ=1, 32x32
    reg_file_multiport_if #(.DATA_W(16), .ADDR_W(4)) b0 ();
    reg_file_multiport_if #(.DATA_W(16), .ADDR_W(4)) b1 ();
    reg_file_multiport_if #(.DATA_W(16), .ADDR_W(4)) b2 ();
    reg_file_multiport_if #(.DATA_W(32), .ADDR_W(5)) b3 ();

    reg_file_multiport #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1), .REG_READ(0))
        dut0 (.Clock(Clock), .Reset(Reset), .bus(b0));
    reg_file_multiport #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0), .REG_READ(0))
        dut1 (.Clock(Clock), .Reset(Reset), .bus(b1));
    reg_file_multiport #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1), .REG_READ(0))
        dut2 (.Clock(Clock), .Reset(Reset), .bus(b2));
    reg_file_multiport #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1), .REG_READ(1))
        dut3 (.Clock(Clock), .Reset(Reset), .bus(b3));

    // clock/reset block
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // reference state for the registered-read instance
    logic [31:0] mReg   [32];
    logic        mBusy  [32];
    logic        preBusy[32];
    logic        wrote  [32];

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_inputs();
        b0.WriteEnable0 = 0; b0.WriteEnable1 = 0; b0.ReserveEnable = 0;
        b1.WriteEnable0 = 0; b1.WriteEnable1 = 0; b1.ReserveEnable = 0;
        b2.WriteEnable0 = 0; b2.WriteEnable1 = 0; b2.ReserveEnable = 0;
        b3.WriteEnable0 = 0; b3.WriteEnable1 = 0; b3.ReserveEnable = 0;
    endtask

    task automatic init_inputs();
        clear_inputs();
        b0.SelectInput0 = 0; b0.SelectInput1 = 0; b0.In0 = 0; b0.In1 = 0;
        b0.ReserveSelect = 0; b0.SelectA = 0; b0.SelectB = 0;
        b1.SelectInput0 = 0; b1.SelectInput1 = 0; b1.In0 = 0; b1.In1 = 0;
        b1.ReserveSelect = 0; b1.SelectA = 0; b1.SelectB = 0;
        b2.SelectInput0 = 0; b2.SelectInput1 = 0; b2.In0 = 0; b2.In1 = 0;
        b2.ReserveSelect = 0; b2.SelectA = 0; b2.SelectB = 0;
        b3.SelectInput0 = 0; b3.SelectInput1 = 0; b3.In0 = 0; b3.In1 = 0;
        b3.ReserveSelect = 0; b3.SelectA = 0; b3.SelectB = 0;
    endtask

    task automatic test_reset();
        // R3 = 0x1234 with a reserve in the same cycle -> busy stays set
        b0.WriteEnable0 = 1; b0.SelectInput0 = 3; b0.In0 = 16'h1234;
        b0.ReserveEnable = 1; b0.ReserveSelect = 3;
        step();
        clear_inputs();
        b0.SelectA = 3;
        #1;
        checks++;
        if (b0.A !== 16'h1234) begin
            failures++; $display("FAIL reset_pre_A got=%h exp=%h", b0.A, 16'h1234);
        end
        checks++;
        if (b0.BusyA !== 1'b1) begin
            failures++; $display("FAIL reset_pre_busy got=%b exp=1", b0.BusyA);
        end
        // pending write present when reset asserts, mid-cycle
        b0.WriteEnable0 = 1; b0.SelectInput0 = 3; b0.In0 = 16'h9999;
        Reset = 0;
        #1;
        checks++;
        if (b0.A !== 16'h0000) begin
            failures++; $display("FAIL reset_async_A got=%h exp=%h", b0.A, 16'h0000);
        end
        checks++;
        if (b0.BusyA !== 1'b0) begin
            failures++; $display("FAIL reset_async_busy got=%b exp=0", b0.BusyA);
        end
        checks++;
        if (b3.A !== 32'h0 || b3.BusyA !== 1'b0) begin
            failures++; $display("FAIL reset_regread got=%h/%b exp=0/0", b3.A, b3.BusyA);
        end
        step();
        clear_inputs();
        Reset = 1;
        #1;
        checks++;
        if (b0.A !== 16'h0000) begin
            failures++; $display("FAIL reset_discard_A got=%h exp=%h", b0.A, 16'h0000);
        end
    endtask

    task automatic test_write_priority();
        b0.WriteEnable0 = 1; b0.SelectInput0 = 5; b0.In0 = 16'hAAAA;
        b0.WriteEnable1 = 1; b0.SelectInput1 = 5; b0.In1 = 16'h5555;
        b0.SelectA = 5;
        #1;
        checks++;
        if (b0.A !== 16'h5555) begin
            failures++; $display("FAIL prio_bypass got=%h exp=%h", b0.A, 16'h5555);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (b0.A !== 16'h5555) begin
            failures++; $display("FAIL prio_stored got=%h exp=%h", b0.A, 16'h5555);
        end
        // both read ports on the same address
        b0.SelectB = 5;
        #1;
        checks++;
        if (b0.B !== 16'h5555) begin
            failures++; $display("FAIL same_sel_B got=%h exp=%h", b0.B, 16'h5555);
        end
    endtask

    task automatic test_bypass();
        b0.WriteEnable1 = 1; b0.SelectInput1 = 7; b0.In1 = 16'hBEEF; b0.SelectB = 7;
        b1.WriteEnable1 = 1; b1.SelectInput1 = 7; b1.In1 = 16'hBEEF; b1.SelectB = 7;
        #1;
        checks++;
        if (b0.B !== 16'hBEEF) begin
            failures++; $display("FAIL bypass_on got=%h exp=%h", b0.B, 16'hBEEF);
        end
        checks++;
        if (b1.B !== 16'h0000) begin
            failures++; $display("FAIL bypass_off_old got=%h exp=%h", b1.B, 16'h0000);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (b1.B !== 16'hBEEF) begin
            failures++; $display("FAIL bypass_off_new got=%h exp=%h", b1.B, 16'hBEEF);
        end
    endtask

    task automatic test_busy();
        b0.ReserveEnable = 1; b0.ReserveSelect = 2; b0.SelectA = 2;
        step();
        clear_inputs();
        #1;
        checks++;
        if (b0.BusyA !== 1'b1) begin
            failures++; $display("FAIL busy_reserved got=%b exp=1", b0.BusyA);
        end
        // write clears busy; bypassed read already sees the post-edge busy value
        b0.WriteEnable0 = 1; b0.SelectInput0 = 2; b0.In0 = 16'h0042;
        #1;
        checks++;
        if (b0.BusyA !== 1'b0 || b0.A !== 16'h0042) begin
            failures++; $display("FAIL busy_bypass got=%b/%h exp=0/0042", b0.BusyA, b0.A);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (b0.BusyA !== 1'b0 || b0.A !== 16'h0042) begin
            failures++; $display("FAIL busy_cleared got=%b/%h exp=0/0042", b0.BusyA, b0.A);
        end
        // reserve + write same cycle -> stays busy, new data
        b0.WriteEnable1 = 1; b0.SelectInput1 = 2; b0.In1 = 16'h0077;
        b0.ReserveEnable = 1; b0.ReserveSelect = 2;
        #1;
        checks++;
        if (b0.BusyA !== 1'b1 || b0.A !== 16'h0077) begin
            failures++; $display("FAIL busy_resv_wr_comb got=%b/%h exp=1/0077", b0.BusyA, b0.A);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (b0.BusyA !== 1'b1 || b0.A !== 16'h0077) begin
            failures++; $display("FAIL busy_resv_wr got=%b/%h exp=1/0077", b0.BusyA, b0.A);
        end
        // port B is independent and sees an unreserved register
        b0.SelectB = 5;
        #1;
        checks++;
        if (b0.BusyB !== 1'b0 || b0.B !== 16'h5555) begin
            failures++; $display("FAIL busy_portB got=%b/%h exp=0/5555", b0.BusyB, b0.B);
        end
    endtask

    task automatic test_zero_reg();
        b2.WriteEnable0 = 1; b2.SelectInput0 = 0; b2.In0 = 16'hFFFF;
        b2.WriteEnable1 = 1; b2.SelectInput1 = 1; b2.In1 = 16'h1111;
        b2.ReserveEnable = 1; b2.ReserveSelect = 0;
        b2.SelectA = 0; b2.SelectB = 1;
        #1;
        checks++;
        if (b2.A !== 16'h0000) begin
            failures++; $display("FAIL zero_comb got=%h exp=%h", b2.A, 16'h0000);
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if (b2.A !== 16'h0000 || b2.BusyA !== 1'b0) begin
            failures++; $display("FAIL zero_reg got=%h/%b exp=0000/0", b2.A, b2.BusyA);
        end
        checks++;
        if (b2.B !== 16'h1111) begin
            failures++; $display("FAIL zero_r1 got=%h exp=%h", b2.B, 16'h1111);
        end
    endtask

    task automatic test_reg_read();
        logic [31:0] expA, expB;
        logic        expBa, expBb;
        logic        we0, we1, re;
        logic [4:0]  s0, s1, rs, sa, sb;
        logic [31:0] d0, d1;
        b3.WriteEnable0 = 1; b3.SelectInput0 = 4; b3.In0 = 32'h0000_0C0C;
        step();
        clear_inputs();
        b3.SelectA = 4;
        #1;
        checks++;
        if (b3.A !== 32'h0) begin
            failures++; $display("FAIL regread_early got=%h exp=%h", b3.A, 32'h0);
        end
        step();
        checks++;
        if (b3.A !== 32'h0000_0C0C) begin
            failures++; $display("FAIL regread_latency got=%h exp=%h", b3.A, 32'h0000_0C0C);
        end
        for (int i = 0; i < 32; i++) begin
            mReg[i] = '0; mBusy[i] = 1'b0;
        end
        mReg[4] = 32'h0000_0C0C;
        for (int c = 0; c < 400; c++) begin
            we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            re  = 1'($urandom_range(0, 1));
            s0 = 5'($urandom_range(0, 7)); s1 = 5'($urandom_range(0, 7));
            rs = 5'($urandom_range(0, 7)); sa = 5'($urandom_range(0, 7));
            sb = 5'($urandom_range(0, 7));
            d0 = $urandom; d1 = $urandom;
            b3.WriteEnable0 = we0; b3.SelectInput0 = s0; b3.In0 = d0;
            b3.WriteEnable1 = we1; b3.SelectInput1 = s1; b3.In1 = d1;
            b3.ReserveEnable = re; b3.ReserveSelect = rs;
            b3.SelectA = sa; b3.SelectB = sb;
            // Model: apply the edge first; with bypass, data reads always match the
            // post-edge contents, busy is post-edge only for addresses written now.
            for (int i = 0; i < 32; i++) begin
                preBusy[i] = mBusy[i]; wrote[i] = 1'b0;
            end
            if (we0) begin mReg[s0] = d0; mBusy[s0] = 1'b0; wrote[s0] = 1'b1; end
            if (we1) begin mReg[s1] = d1; mBusy[s1] = 1'b0; wrote[s1] = 1'b1; end
            if (re) mBusy[rs] = 1'b1;
            expA  = mReg[sa];
            expB  = mReg[sb];
            expBa = wrote[sa] ? mBusy[sa] : preBusy[sa];
            expBb = wrote[sb] ? mBusy[sb] : preBusy[sb];
            step();
            checks++;
            if (b3.A !== expA || b3.B !== expB || b3.BusyA !== expBa || b3.BusyB !== expBb) begin
                failures++;
                $display("FAIL regread_rand c=%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b",
                         c, b3.A, b3.B, b3.BusyA, b3.BusyB, expA, expB, expBa, expBb);
            end
        end
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 0;
        init_inputs();
        repeat (3) step();
        Reset = 1;
        step();
        test_reset();
        step();
        test_write_priority();
        step();
        test_bypass();
        step();
        test_busy();
        step();
        test_zero_reg();
        step();
        test_reg_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
